mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Memory-stage access controller between the EX/MEM pipeline register and the MEM/WB register. It consumes ALUResultM, WriteDataM, MemWriteM, ResultSrcM and Funct3M. It drives a request/grant/valid data bus with byte enables, and returns aligned, sign- or zero-extended load data. It also stalls the pipeline (StallM) until the access completes, times out, or is rejected as misaligned.

Parameters:
TIMEOUT_CYCLES, 255, cycles waited for dgnt or drvalid before BusErrM; must be at most 2**CNT_W-1
CNT_W, 8, width of the timeout counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
ALUResultM  in  32  effective byte address
WriteDataM  in  32  store data, unaligned, from rs2
MemWriteM  in  1  store request
ResultSrcM  in  2  2'b01 = load request
Funct3M  in  3  width/sign select: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
ReadDataM  out  32  extended load data; valid in DONE
StallM  out  1  holds PC, IF/ID, ID/EX and EX/MEM registers
MisalignM  out  1  misaligned access flag, combinational
BusErrM  out  1  timeout flag, valid in DONE
dreq  out  1  bus request
dwe  out  1  1 = write
daddr  out  32  word-aligned address ({addr[31:2],2'b00})
dwdata  out  32  lane-replicated store data
dbe  out  4  byte enables
dgnt  in  1  request accepted
drvalid  in  1  read data valid
drdata  in  32  read data word

Behaviour:
- Access is defined as acc = MemWriteM | (ResultSrcM==2'b01). If both are set, the access is treated as a store.
- Misalignment:
  - mis = acc & ((word & addr[1:0]!=0) | (half & addr[0])).
  - MisalignM = mis in IDLE.
  - No bus request is issued; StallM=0; ReadDataM=0.
- FSM states are IDLE, REQ, WAIT_R and DONE.
  - IDLE:
    - If acc & !mis: dreq=1 this cycle (combinational), StallM=1, and addr/wdata/be/we/funct3 are captured into holding registers.
    - If dgnt=1 in the same cycle: a store goes to DONE; a load goes to WAIT_R.
    - Otherwise, go to REQ.
  - REQ:
    - dreq=1, with bus outputs taken from the holding registers. StallM=1.
    - On dgnt: a store goes to DONE; a load goes to WAIT_R.
  - WAIT_R:
    - dreq=0, StallM=1.
    - On drvalid: capture drdata and go to DONE. drvalid in the same cycle as dgnt is ignored; rvalid is accepted at the earliest 1 cycle after the grant.
  - DONE:
    - StallM=0 and ReadDataM is driven from the captured data through load extension. The pipeline advances at the closing edge.
    - Next state is IDLE unconditionally. No new request is issued in DONE.
- Latency when granted immediately:
  - Store: 1 stall cycle.
  - Load: 2 stall cycles (rvalid arriving 1 cycle after grant).
- Timeout:
  - The counter clears on entry to REQ/WAIT_R and increments each cycle spent there.
  - When count==TIMEOUT_CYCLES, go to DONE with BusErrM=1 and ReadDataM=0. dreq drops.
- Store lanes:
  - SB: dwdata={4{wd[7:0]}}, dbe=4'b0001<<addr[1:0].
  - SH: dwdata={2{wd[15:0]}}, dbe = addr[1] ? 4'b1100 : 4'b0011.
  - SW: dbe=4'b1111.
  - Loads: dbe=4'b1111 and dwe=0.
- Load extension:
  - Select the byte/half lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
  - Funct3 values 011/110/111 are treated as LW.
- Outside DONE, ReadDataM=0 and BusErrM=0. dreq=0 in WAIT_R and DONE.
- Reset (at any time, asynchronous):
  - State goes to IDLE; holding registers, counter and captured data clear to 0.
  - dreq, dwe, dbe, daddr, dwdata, ReadDataM, BusErrM and StallM read 0 while reset=1.
  - A bus transaction in flight is abandoned.

Decomposition:
- Package mem_pkg holds:
  - the state enum (IDLE, REQ, WAIT_R, DONE);
  - Funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - RESULT_SRC_MEM=2'b01.
- Sub-module load_extend is combinational: (rdata, addr[1:0], funct3) -> 32-bit extended data. It is reused by the verification model.

Test Plan:
- SW at 0x00000010 of 0xDEADBEEF, dgnt=1 immediately -> dreq/dwe=1, daddr=0x10, dbe=1111; StallM=1 for 1 cycle, DONE next cycle.
- SB at 0x00000013 of 0x000000A5 -> dwdata=0xA5A5A5A5, dbe=1000. LH at 0x00000002 with drdata=0x8001_1234 -> ReadDataM=0xFFFF8001. LHU at the same address -> ReadDataM=0x00008001.
- LB at 0x00000001, dgnt delayed 3 cycles, drvalid 2 cycles later with drdata=0x0000F000 -> StallM=1 for 6 cycles. ReadDataM=0xFFFFFFF0 in DONE.
- LW at 0x00000006 -> MisalignM=1, dreq=0, StallM=0, ReadDataM=0.
- LW with dgnt held 0 and TIMEOUT_CYCLES=4 -> dreq drops after the timeout; DONE has BusErrM=1, ReadDataM=0; then IDLE.
- Reset asserted while in WAIT_R -> dreq/StallM go to 0 immediately. After release, the next SW issues cleanly from IDLE and a late drvalid is ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage access unit.
// State encoding, funct3 width codes and the load result-source code.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  function automatic logic isByte(input logic [2:0] f3);
    return f3[1:0] == F3_B[1:0];
  endfunction

  function automatic logic isHalf(input logic [2:0] f3);
    return f3[1:0] == F3_H[1:0];
  endfunction

  // 011/110/111 fall into the word class as well
  function automatic logic isWord(input logic [2:0] f3);
    return (f3[1:0] == F3_W[1:0]) | (f3[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load lane select and sign/zero extension (combinational).
// rdata: bus word, addr: byte offset, funct3: width/sign, data: result.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    unique case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_BU:   data = {24'd0, b};
      F3_HU:   data = {16'd0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: EX/MEM fields to req/gnt/rvalid bus, stalls.
// Ports: pipeline in (ALUResultM..Funct3M), ReadDataM/StallM/flags, d* bus.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  Funct3M,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        dreq,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dbe,
  input  logic        dgnt,
  input  logic        drvalid,
  input  logic [31:0] drdata
);

  state_t           state;
  logic [31:0]      addrR;
  logic [31:0]      wdR;
  logic [3:0]       beR;
  logic             weR;
  logic [2:0]       f3R;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rdataR;
  logic             errR;

  logic        acc;
  logic        mis;
  logic        start;
  logic        timeUp;
  logic [31:0] wdIn;
  logic [3:0]  beIn;
  logic [31:0] extData;

  assign acc = MemWriteM | (ResultSrcM == RESULT_SRC_MEM);
  assign mis = acc & ((isWord(Funct3M) & (|ALUResultM[1:0]))
                    | (isHalf(Funct3M) & ALUResultM[0]));
  assign start  = (state == IDLE) & acc & ~mis;
  assign timeUp = cnt == CNT_W'(TIMEOUT_CYCLES);
  assign MisalignM = (state == IDLE) & mis;

  always_comb begin
    wdIn = WriteDataM;
    beIn = 4'b1111;
    unique case (1'b1)
      isByte(Funct3M): begin
        wdIn = {4{WriteDataM[7:0]}};
        if (MemWriteM) beIn = 4'b0001 << ALUResultM[1:0];
      end
      isHalf(Funct3M): begin
        wdIn = {2{WriteDataM[15:0]}};
        if (MemWriteM) beIn = ALUResultM[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  load_extend u_ext (
    .rdata (rdataR),
    .addr  (addrR[1:0]),
    .funct3(f3R),
    .data  (extData)
  );

  // Reset forces every bus/pipeline output low, including the
  // combinational request issued straight from IDLE.
  always_comb begin
    dreq      = 1'b0;
    dwe       = 1'b0;
    daddr     = 32'd0;
    dwdata    = 32'd0;
    dbe       = 4'd0;
    StallM    = 1'b0;
    ReadDataM = 32'd0;
    BusErrM   = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: if (start) begin
          dreq   = 1'b1;
          dwe    = MemWriteM;
          daddr  = {ALUResultM[31:2], 2'b00};
          dwdata = wdIn;
          dbe    = beIn;
          StallM = 1'b1;
        end
        REQ: begin
          dreq   = 1'b1;
          dwe    = weR;
          daddr  = {addrR[31:2], 2'b00};
          dwdata = wdR;
          dbe    = beR;
          StallM = 1'b1;
        end
        WAIT_R: StallM = 1'b1;
        DONE: begin
          BusErrM   = errR;
          ReadDataM = errR ? 32'd0 : extData;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      addrR  <= '0;
      wdR    <= '0;
      beR    <= '0;
      weR    <= 1'b0;
      f3R    <= '0;
      cnt    <= '0;
      rdataR <= '0;
      errR   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          addrR  <= ALUResultM;
          wdR    <= wdIn;
          beR    <= beIn;
          weR    <= MemWriteM;
          f3R    <= Funct3M;
          rdataR <= '0;
          errR   <= 1'b0;
          cnt    <= '0;
          if (dgnt) state <= MemWriteM ? DONE : WAIT_R;
          else      state <= REQ;
        end
        REQ: begin
          // a grant on the final counted cycle still wins
          if (dgnt) begin
            state <= weR ? DONE : WAIT_R;
            cnt   <= '0;
          end else if (timeUp) begin
            state <= DONE;
            errR  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_R: begin
          if (drvalid) begin
            rdataR <= drdata;
            state  <= DONE;
          end else if (timeUp) begin
            state <= DONE;
            errR  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a queue of expected results.
// Bus responder timing is scripted per access (grant and rvalid cycles).
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;
  logic        BusErrM;
  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dbe;
  logic        dgnt;
  logic        drvalid;
  logic [31:0] drdata;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .MemWriteM (MemWriteM),
    .ResultSrcM(ResultSrcM),
    .Funct3M   (Funct3M),
    .ReadDataM (ReadDataM),
    .StallM    (StallM),
    .MisalignM (MisalignM),
    .BusErrM   (BusErrM),
    .dreq      (dreq),
    .dwe       (dwe),
    .daddr     (daddr),
    .dwdata    (dwdata),
    .dbe       (dbe),
    .dgnt      (dgnt),
    .drvalid   (drvalid),
    .drdata    (drdata)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          stall;
    int          reqs;
  } exp_t;

  exp_t sb[$];
  int nCmp = 0;
  int nBad = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idleIn();
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b00;
    Funct3M    = 3'b000;
    ALUResultM = 32'd0;
    WriteDataM = 32'd0;
    dgnt       = 1'b0;
    drvalid    = 1'b0;
    drdata     = 32'h5A5A5A5A;
  endtask

  // Called at posedge+1; returns at posedge+1 with the unit back in IDLE.
  task automatic access(input string tag, input logic we,
                        input logic [1:0] rs, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int gntAt, input int rvAfter,
                        input logic [31:0] rd, input logic [3:0] expBe,
                        input logic [31:0] expWd, input logic [31:0] expRd,
                        input logic expErr, input int expStall,
                        input int expReqs);
    exp_t e;
    int stalls;
    int reqs;
    bit done;
    logic [31:0] wordAddr;
    wordAddr = {addr[31:2], 2'b00};
    sb.push_back('{expRd, expErr, expStall, expReqs});
    MemWriteM  = we;
    ResultSrcM = rs;
    Funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    stalls = 0;
    reqs   = 0;
    done   = 0;
    for (int c = 0; c < 64; c++) begin
      dgnt    = (c == gntAt);
      drvalid = (gntAt >= 0) && (c == gntAt + rvAfter);
      drdata  = drvalid ? rd : 32'h5A5A5A5A;
      @(negedge clk);
      if (c == 0) begin
        check({tag, " daddr"}, daddr, wordAddr);
        check({tag, " dbe"}, {28'd0, dbe}, {28'd0, expBe});
        check({tag, " dwe"}, {31'd0, dwe}, {31'd0, we});
        check({tag, " mis"}, {31'd0, MisalignM}, 32'd0);
        if (we) check({tag, " dwdata"}, dwdata, expWd);
      end
      if (dreq) reqs++;
      if (!StallM) begin
        e = sb.pop_front();
        check({tag, " rdata"}, ReadDataM, e.rd);
        check({tag, " buserr"}, {31'd0, BusErrM}, {31'd0, e.err});
        check({tag, " stalls"}, 32'(stalls), 32'(e.stall));
        check({tag, " reqs"}, 32'(reqs), 32'(e.reqs));
        check({tag, " dreq@done"}, {31'd0, dreq}, 32'd0);
        done = 1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
      if (done) break;
    end
    if (!done) begin
      nCmp++;
      nBad++;
      $error("FAIL %s done: got none expected done within 64", tag);
      void'(sb.pop_front());
    end
    idleIn();
    @(negedge clk);
    check({tag, " idle stall"}, {31'd0, StallM}, 32'd0);
    check({tag, " idle rdata"}, ReadDataM, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idleIn();
    reset      = 1'b1;
    MemWriteM  = 1'b1;
    Funct3M    = F3_W;
    ALUResultM = 32'h10;
    @(negedge clk);
    check("rst dreq", {31'd0, dreq}, 32'd0);
    check("rst stall", {31'd0, StallM}, 32'd0);
    check("rst dbe", {28'd0, dbe}, 32'd0);
    check("rst rdata", ReadDataM, 32'd0);
    @(posedge clk);
    #1;
    idleIn();
    reset = 1'b0;
    @(posedge clk);
    #1;

    access("SW", 1, 2'b00, F3_W, 32'h10, 32'hDEADBEEF, 0, 1, 0,
           4'b1111, 32'hDEADBEEF, 32'd0, 0, 1, 1);
    access("SB", 1, 2'b00, F3_B, 32'h13, 32'h000000A5, 0, 1, 0,
           4'b1000, 32'hA5A5A5A5, 32'd0, 0, 1, 1);
    access("LH", 0, RESULT_SRC_MEM, F3_H, 32'h2, 0, 0, 1, 32'h80011234,
           4'b1111, 0, 32'hFFFF8001, 0, 2, 1);
    access("LHU", 0, RESULT_SRC_MEM, F3_HU, 32'h2, 0, 0, 1, 32'h80011234,
           4'b1111, 0, 32'h00008001, 0, 2, 1);
    access("LBslow", 0, RESULT_SRC_MEM, F3_B, 32'h1, 0, 3, 2, 32'h0000F000,
           4'b1111, 0, 32'hFFFFFFF0, 0, 6, 4);
    access("SH", 1, 2'b00, F3_H, 32'h2, 32'h1234ABCD, 0, 1, 0,
           4'b1100, 32'hABCDABCD, 32'd0, 0, 1, 1);
    access("LBU", 0, RESULT_SRC_MEM, F3_BU, 32'h3, 0, 0, 1, 32'h80000000,
           4'b1111, 0, 32'h00000080, 0, 2, 1);
    access("LB3", 0, RESULT_SRC_MEM, F3_B, 32'h3, 0, 0, 1, 32'h80000000,
           4'b1111, 0, 32'hFFFFFF80, 0, 2, 1);
    access("LW011", 0, RESULT_SRC_MEM, 3'b011, 32'h8, 0, 0, 1, 32'hCAFEF00D,
           4'b1111, 0, 32'hCAFEF00D, 0, 2, 1);
    access("SWboth", 1, RESULT_SRC_MEM, F3_W, 32'h4, 32'h11223344, 0, 1, 0,
           4'b1111, 32'h11223344, 32'd0, 0, 1, 1);
    access("LWtmo", 0, RESULT_SRC_MEM, F3_W, 32'h40, 0, -1, 1, 0,
           4'b1111, 0, 32'd0, 1, 6, 6);

    // misaligned word and half loads
    MemWriteM  = 1'b0;
    ResultSrcM = RESULT_SRC_MEM;
    Funct3M    = F3_W;
    ALUResultM = 32'h6;
    @(negedge clk);
    check("misW flag", {31'd0, MisalignM}, 32'd1);
    check("misW dreq", {31'd0, dreq}, 32'd0);
    check("misW stall", {31'd0, StallM}, 32'd0);
    check("misW rdata", ReadDataM, 32'd0);
    @(posedge clk);
    #1;
    Funct3M    = F3_H;
    ALUResultM = 32'h1;
    @(negedge clk);
    check("misH flag", {31'd0, MisalignM}, 32'd1);
    check("misH dreq", {31'd0, dreq}, 32'd0);
    @(posedge clk);
    #1;

    // reset while waiting for read data
    ALUResultM = 32'h20;
    Funct3M    = F3_W;
    dgnt       = 1'b1;
    @(posedge clk);
    #1;
    dgnt = 1'b0;
    @(negedge clk);
    check("wait stall", {31'd0, StallM}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rstW dreq", {31'd0, dreq}, 32'd0);
    check("rstW stall", {31'd0, StallM}, 32'd0);
    @(posedge clk);
    #1;
    idleIn();
    reset = 1'b0;
    drvalid = 1'b1;
    drdata  = 32'h12345678;
    @(negedge clk);
    check("late rv stall", {31'd0, StallM}, 32'd0);
    check("late rv rdata", ReadDataM, 32'd0);
    @(posedge clk);
    #1;
    drvalid = 1'b0;
    access("SWpost", 1, 2'b00, F3_W, 32'h30, 32'h0BADF00D, 0, 1, 0,
           4'b1111, 32'h0BADF00D, 32'd0, 0, 1, 1);

    check("sb empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
